// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the arithmetic unit and its downstream stages:
// ALU_FUN op-code encodings, the default result width and the packed
// result record that the result FIFO stores per entry.
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    MUL = 2'b10,
    DIV = 2'b11
  } alu_fun_e;

  // One captured ALU result: payload word, carry out and the op that made it.
  typedef struct packed {
    logic [ALU_DATA_WIDTH-1:0] data;
    logic                      carry;
    alu_fun_e                  fun;
  } alu_result_t;

endpackage

// File: rtl/alu_result_mem.sv
// alu_result_mem
// DEPTH-entry register array holding alu_result_t records for the result
// FIFO. One synchronous write port, one asynchronous (combinational) read
// port. Storage is deliberately not reset; validity is tracked by the
// owner through its occupancy count.
//
// Ports:
//   Clk      in   clock, writes on rising edge
//   Wr_En    in   write strobe
//   Wr_Addr  in   write address
//   Wr_Entry in   record to store
//   Rd_Addr  in   read address
//   Rd_Entry out  record at Rd_Addr
module alu_result_mem
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Wr_En,
  input  logic [PTR_W-1:0] Wr_Addr,
  input  alu_result_t      Wr_Entry,
  input  logic [PTR_W-1:0] Rd_Addr,
  output alu_result_t      Rd_Entry
);

  alu_result_t mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (Wr_En) begin
      mem[Wr_Addr] <= Wr_Entry;
    end
  end

  assign Rd_Entry = mem[Rd_Addr];

endmodule

// File: rtl/alu_result_fifo.sv
// alu_result_fifo
// Captures each registered ALU result (data, carry, op tag) whenever the
// ALU flag strobe is high, buffers it in a small first-word-fall-through
// FIFO and hands it to the consumer over a valid/ready handshake. Pushes
// that arrive while the FIFO is full and not draining are dropped and
// recorded in a sticky overflow flag.
//
// Ports:
//   Clk       in   clock, all state on rising edge
//   RST       in   synchronous active-high reset
//   In_Data   in   ALU result word
//   In_Carry  in   ALU carry
//   In_Fun    in   ALU_FUN code (stored as tag)
//   In_Flag   in   push strobe
//   Out_Ready in   consumer takes the head entry this cycle
//   Ovf_Clr   in   clears the sticky overflow flag
//   Out_Valid out  head entry is valid
//   Out_Data  out  head result word (0 when empty)
//   Out_Carry out  head carry (0 when empty)
//   Out_Fun   out  head op tag (0 when empty)
//   Full      out  Count == DEPTH
//   Empty     out  Count == 0
//   Count     out  occupancy 0..DEPTH
//   Overflow  out  sticky: at least one push was dropped
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int DEPTH      = 4,
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                  Clk,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] In_Data,
  input  logic                  In_Carry,
  input  logic [1:0]            In_Fun,
  input  logic                  In_Flag,
  input  logic                  Out_Ready,
  input  logic                  Ovf_Clr,
  output logic                  Out_Valid,
  output logic [DATA_WIDTH-1:0] Out_Data,
  output logic                  Out_Carry,
  output logic [1:0]            Out_Fun,
  output logic                  Full,
  output logic                  Empty,
  output logic [CNT_WIDTH-1:0]  Count,
  output logic                  Overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             drop;
  alu_result_t      wr_entry;
  alu_result_t      rd_entry;

  assign Empty     = (Count == '0);
  assign Full      = (Count == CNT_WIDTH'(DEPTH));
  assign Out_Valid = !Empty;

  assign pop  = Out_Valid && Out_Ready;
  // A full FIFO can still accept a push when the head leaves the same cycle.
  assign push = In_Flag && (!Full || pop);
  assign drop = In_Flag && Full && !pop;

  // The entry record's payload width comes from the package; the casts keep
  // the port width independent of it.
  assign wr_entry.data  = ALU_DATA_WIDTH'(In_Data);
  assign wr_entry.carry = In_Carry;
  assign wr_entry.fun   = alu_fun_e'(In_Fun);

  alu_result_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .Clk      (Clk),
    .Wr_En    (push && !RST),
    .Wr_Addr  (wr_ptr),
    .Wr_Entry (wr_entry),
    .Rd_Addr  (rd_ptr),
    .Rd_Entry (rd_entry)
  );

  // Stale storage is masked so the head reads as zero when nothing is held.
  assign Out_Data  = Empty ? '0   : DATA_WIDTH'(rd_entry.data);
  assign Out_Carry = Empty ? 1'b0 : rd_entry.carry;
  assign Out_Fun   = Empty ? 2'b00 : rd_entry.fun;

  always_ff @(posedge Clk) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      Overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   Count <= Count + CNT_WIDTH'(1);
        2'b01:   Count <= Count - CNT_WIDTH'(1);
        default: Count <= Count;
      endcase

      // A new drop outranks a clear in the same cycle.
      if (drop) begin
        Overflow <= 1'b1;
      end else if (Ovf_Clr) begin
        Overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;

  logic        Clk;
  logic        RST;
  logic [15:0] In_Data;
  logic        In_Carry;
  logic [1:0]  In_Fun;
  logic        In_Flag;
  logic        Out_Ready;
  logic        Ovf_Clr;
  logic        Out_Valid;
  logic [15:0] Out_Data;
  logic        Out_Carry;
  logic [1:0]  Out_Fun;
  logic        Full;
  logic        Empty;
  logic [2:0]  Count;
  logic        Overflow;

  int n_pass  = 0;
  int n_total = 0;

  alu_result_fifo #(
    .DATA_WIDTH(16),
    .DEPTH(4)
  ) dut (
    .Clk       (Clk),
    .RST       (RST),
    .In_Data   (In_Data),
    .In_Carry  (In_Carry),
    .In_Fun    (In_Fun),
    .In_Flag   (In_Flag),
    .Out_Ready (Out_Ready),
    .Ovf_Clr   (Ovf_Clr),
    .Out_Valid (Out_Valid),
    .Out_Data  (Out_Data),
    .Out_Carry (Out_Carry),
    .Out_Fun   (Out_Fun),
    .Full      (Full),
    .Empty     (Empty),
    .Count     (Count),
    .Overflow  (Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic        flag;
    logic [15:0] d;
    logic        c;
    logic [1:0]  f;
    logic        rdy;
    logic        clr;
    logic [15:0] e_data;
    logic        e_carry;
    logic [1:0]  e_fun;
    logic [2:0]  e_cnt;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic flag, input logic [15:0] d,
                              input logic c, input logic [1:0] f, input logic rdy,
                              input logic clr, input logic [15:0] e_data,
                              input logic e_carry, input logic [1:0] e_fun,
                              input logic [2:0] e_cnt, input logic e_ovf);
    vec_t v;
    v.rst = rst; v.flag = flag; v.d = d; v.c = c; v.f = f; v.rdy = rdy; v.clr = clr;
    v.e_data = e_data; v.e_carry = e_carry; v.e_fun = e_fun;
    v.e_cnt = e_cnt; v.e_ovf = e_ovf;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
  endtask

  // Valid/Full/Empty are implied by the expected occupancy.
  task automatic check_all(input int idx, input logic [15:0] e_data, input logic e_carry,
                           input logic [1:0] e_fun, input logic [2:0] e_cnt,
                           input logic e_ovf);
    chk("count", idx, 32'(Count), 32'(e_cnt));
    chk("empty", idx, 32'(Empty), 32'(e_cnt == 3'd0));
    chk("full", idx, 32'(Full), 32'(e_cnt == 3'd4));
    chk("valid", idx, 32'(Out_Valid), 32'(e_cnt != 3'd0));
    chk("data", idx, 32'(Out_Data), 32'(e_data));
    chk("carry", idx, 32'(Out_Carry), 32'(e_carry));
    chk("fun", idx, 32'(Out_Fun), 32'(e_fun));
    chk("overflow", idx, 32'(Overflow), 32'(e_ovf));
  endtask

  task automatic drive(input logic rst, input logic flag, input logic [15:0] d,
                       input logic c, input logic [1:0] f, input logic rdy, input logic clr);
    RST = rst; In_Flag = flag; In_Data = d; In_Carry = c; In_Fun = f;
    Out_Ready = rdy; Ovf_Clr = clr;
    @(posedge Clk);
    #1;
  endtask

  task automatic fill_1_to_4();
    add(0, 1, 16'h0001, 0, 2'd1, 0, 0, 16'h0001, 0, 2'd1, 3'd1, 0);
    add(0, 1, 16'h0002, 1, 2'd2, 0, 0, 16'h0001, 0, 2'd1, 3'd2, 0);
    add(0, 1, 16'h0003, 0, 2'd3, 0, 0, 16'h0001, 0, 2'd1, 3'd3, 0);
    add(0, 1, 16'h0004, 1, 2'd0, 0, 0, 16'h0001, 0, 2'd1, 3'd4, 0);
  endtask

  initial begin
    RST = 1'b1; In_Flag = 1'b0; In_Data = '0; In_Carry = 1'b0; In_Fun = 2'b00;
    Out_Ready = 1'b0; Ovf_Clr = 1'b0;

    // Reset held two cycles with a push strobe present.
    add(1, 1, 16'h9999, 1, 2'd3, 0, 0, 16'h0000, 0, 2'd0, 3'd0, 0);
    add(1, 1, 16'h9999, 1, 2'd3, 0, 0, 16'h0000, 0, 2'd0, 3'd0, 0);
    add(0, 0, 16'h0000, 0, 2'd0, 0, 0, 16'h0000, 0, 2'd0, 3'd0, 0);
    // Single push, then pop.
    add(0, 1, 16'h1234, 1, 2'd0, 0, 0, 16'h1234, 1, 2'd0, 3'd1, 0);
    add(0, 0, 16'h0000, 0, 2'd0, 1, 0, 16'h0000, 0, 2'd0, 3'd0, 0);
    // Fill, overflow, drain, clear.
    fill_1_to_4();
    add(0, 1, 16'h0005, 1, 2'd1, 0, 0, 16'h0001, 0, 2'd1, 3'd4, 1);
    add(0, 0, 16'h0000, 0, 2'd0, 1, 0, 16'h0002, 1, 2'd2, 3'd3, 1);
    add(0, 0, 16'h0000, 0, 2'd0, 1, 0, 16'h0003, 0, 2'd3, 3'd2, 1);
    add(0, 0, 16'h0000, 0, 2'd0, 1, 0, 16'h0004, 1, 2'd0, 3'd1, 1);
    add(0, 0, 16'h0000, 0, 2'd0, 1, 0, 16'h0000, 0, 2'd0, 3'd0, 1);
    add(0, 0, 16'h0000, 0, 2'd0, 0, 1, 16'h0000, 0, 2'd0, 3'd0, 0);
    // Ready while empty: nothing moves.
    add(0, 0, 16'h0000, 0, 2'd0, 1, 0, 16'h0000, 0, 2'd0, 3'd0, 0);
    // Simultaneous push and pop at full.
    fill_1_to_4();
    add(0, 1, 16'h00AA, 1, 2'd2, 1, 0, 16'h0002, 1, 2'd2, 3'd4, 0);
    add(0, 0, 16'h0000, 0, 2'd0, 1, 0, 16'h0003, 0, 2'd3, 3'd3, 0);
    add(0, 0, 16'h0000, 0, 2'd0, 1, 0, 16'h0004, 1, 2'd0, 3'd2, 0);
    add(0, 0, 16'h0000, 0, 2'd0, 1, 0, 16'h00AA, 1, 2'd2, 3'd1, 0);
    add(0, 0, 16'h0000, 0, 2'd0, 1, 0, 16'h0000, 0, 2'd0, 3'd0, 0);
    // Reset mid-operation with push and pop strobes.
    add(0, 1, 16'h0011, 0, 2'd1, 0, 0, 16'h0011, 0, 2'd1, 3'd1, 0);
    add(0, 1, 16'h0022, 0, 2'd2, 0, 0, 16'h0011, 0, 2'd1, 3'd2, 0);
    add(0, 1, 16'h0033, 0, 2'd3, 0, 0, 16'h0011, 0, 2'd1, 3'd3, 0);
    add(1, 1, 16'h0044, 1, 2'd0, 1, 0, 16'h0000, 0, 2'd0, 3'd0, 0);
    add(0, 1, 16'h0BEE, 0, 2'd3, 0, 0, 16'h0BEE, 0, 2'd3, 3'd1, 0);
    add(0, 0, 16'h0000, 0, 2'd0, 1, 0, 16'h0000, 0, 2'd0, 3'd0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].flag, vecs[i].d, vecs[i].c, vecs[i].f,
            vecs[i].rdy, vecs[i].clr);
      check_all(i, vecs[i].e_data, vecs[i].e_carry, vecs[i].e_fun,
                vecs[i].e_cnt, vecs[i].e_ovf);
    end

    // Wrap-around: ten values through an alternating push / pop stream with
    // Out_Ready held high; pointers wrap twice.
    for (int k = 0; k < 10; k++) begin
      logic [15:0] v;
      v = 16'h0100 + 16'(k);
      drive(0, 1, v, v[0], v[1:0], 1, 0);
      check_all(100 + 2 * k, v, v[0], v[1:0], 3'd1, 0);
      drive(0, 0, 16'h0000, 0, 2'd0, 1, 0);
      check_all(101 + 2 * k, 16'h0000, 0, 2'd0, 3'd0, 0);
    end

    // Overflow set and clear in the same cycle: set wins.
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 16'h0200 + 16'(k), 0, 2'd0, 0, 0);
    end
    check_all(200, 16'h0200, 0, 2'd0, 3'd4, 0);
    drive(0, 1, 16'h0FFF, 1, 2'd3, 0, 0);
    check_all(201, 16'h0200, 0, 2'd0, 3'd4, 1);
    drive(0, 1, 16'h0FFE, 1, 2'd3, 0, 1);
    check_all(202, 16'h0200, 0, 2'd0, 3'd4, 1);
    drive(0, 0, 16'h0000, 0, 2'd0, 0, 1);
    check_all(203, 16'h0200, 0, 2'd0, 3'd4, 0);
    for (int k = 1; k < 4; k++) begin
      drive(0, 0, 16'h0000, 0, 2'd0, 1, 0);
      check_all(203 + k, 16'h0200 + 16'(k), 0, 2'd0, 3'(4 - k), 0);
    end
    drive(0, 0, 16'h0000, 0, 2'd0, 1, 0);
    check_all(207, 16'h0000, 0, 2'd0, 3'd0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
